// File: rtl/bus_cycle_arbiter.sv
// CPU6 external memory bus controller: arbitrates CPU vs DMA and sequences
// each access through address, wait and data phases with registered outputs.
module bus_cycle_arbiter #(
   parameter int unsigned WAIT_STATES   = 1,
   parameter int unsigned DMA_MAX_BURST = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   output logic        dma_ack,
   output logic [7:0]  dma_rdata,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_oe,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready,
   output logic [1:0]  grant
);

   localparam logic [3:0] MAX_BURST = 4'(DMA_MAX_BURST);
   localparam logic [7:0] WS_LOAD   = 8'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_DATA} state_e;

   state_e      state_q, state_d;
   logic        own_dma_q, own_dma_d;
   logic        we_q, we_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [3:0]  burst_q, burst_d;
   logic [7:0]  wcnt_q, wcnt_d;

   logic        cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
   logic [7:0]  cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_wdata_q, mem_wdata_d;
   logic        mem_oe_q, mem_oe_d, mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
   logic [1:0]  grant_q, grant_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         own_dma_q   <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         burst_q     <= '0;
         wcnt_q      <= '0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_oe_q    <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         grant_q     <= '0;
      end else begin
         state_q     <= state_d;
         own_dma_q   <= own_dma_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         burst_q     <= burst_d;
         wcnt_q      <= wcnt_d;
         cpu_ack_q   <= cpu_ack_d;
         dma_ack_q   <= dma_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_oe_q    <= mem_oe_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         grant_q     <= grant_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      own_dma_d = own_dma_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      burst_d   = burst_q;
      wcnt_d    = wcnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (cpu_req || dma_req) begin
               // DMA is favoured until it has taken MAX_BURST grants against a waiting CPU
               own_dma_d = dma_req && !(cpu_req && (burst_q == MAX_BURST));
               we_d      = own_dma_d ? dma_we    : cpu_we;
               addr_d    = own_dma_d ? dma_addr  : cpu_addr;
               wdata_d   = own_dma_d ? dma_wdata : cpu_wdata;
               burst_d   = (own_dma_d && cpu_req) ? burst_q + 4'd1 : '0;
               state_d   = S_ADDR;
            end
         end
         S_ADDR: begin
            wcnt_d  = WS_LOAD;
            state_d = ((WS_LOAD == '0) && mem_ready) ? S_DATA : S_WAIT;
         end
         S_WAIT: begin
            wcnt_d = (wcnt_q != '0) ? wcnt_q - 8'd1 : '0;
            if ((wcnt_q <= 8'd1) && mem_ready) state_d = S_DATA;
         end
         S_DATA:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered, so they are derived from the state being entered.
   always_comb begin
      logic busy, enter_data;
      busy        = (state_d != S_IDLE);
      enter_data  = (state_d == S_DATA) && (state_q != S_DATA);
      mem_addr_d  = busy ? addr_d : '0;
      mem_wdata_d = (busy && we_d) ? wdata_d : '0;
      mem_oe_d    = busy && we_d;
      mem_wr_d    = busy && we_d;
      mem_rd_d    = busy && !we_d;
      grant_d     = !busy ? 2'b00 : (own_dma_d ? 2'b10 : 2'b01);
      cpu_ack_d   = enter_data && !own_dma_d;
      dma_ack_d   = enter_data && own_dma_d;
      cpu_rdata_d = (cpu_ack_d && !we_d) ? mem_rdata : '0;
      dma_rdata_d = (dma_ack_d && !we_d) ? mem_rdata : '0;
   end

   assign cpu_ack   = cpu_ack_q;
   assign dma_ack   = dma_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_oe    = mem_oe_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign grant     = grant_q;

endmodule

// File: doc/bus_cycle_arbiter.md
Name:
bus_cycle_arbiter

Overview:
- Controller for the CPU6 external memory bus: 16-bit address bus, 8-bit bidirectional data bus.
- Shares the bus between two requesters: the microcode-driven CPU datapath and a DMA channel.
- Sequences each access as address, wait, then data phase, with a programmable wait-state count and a memory ready input.
- Drives the data-bus output enable used by the top level's tri-state buffer.

Parameters:
- WAIT_STATES, 1: minimum wait-phase cycles per access. 0 skips the WAIT state.
- DMA_MAX_BURST, 4: maximum consecutive DMA grants while cpu_req is pending. Range 1-15.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_req  input  1  CPU access request; held until cpu_ack.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  16  CPU address.
- cpu_wdata  input  8  CPU write data.
- cpu_ack  output  1  one-cycle completion strobe.
- cpu_rdata  output  8  read data, valid while cpu_ack=1.
- dma_req, dma_we, dma_addr[16], dma_wdata[8]  input  DMA equivalents of the CPU request signals.
- dma_ack  output  1  DMA completion strobe.
- dma_rdata  output  8  DMA read data, valid while dma_ack=1.
- mem_addr  output  16  external address bus.
- mem_wdata  output  8  data driven onto the bus during writes.
- mem_oe  output  1  data-bus drive enable; 1 only during write cycles.
- mem_rd  output  1  read strobe.
- mem_wr  output  1  write strobe.
- mem_rdata  input  8  data bus input.
- mem_ready  input  1  memory ready; low extends the wait phase.
- grant  output  2  01 = CPU owns the bus, 10 = DMA owns it, 00 = idle.

Behaviour:
Reset and registers
- Reset (synchronous, active-high) sets: state IDLE, all outputs 0, burst counter 0, wait counter 0.
- Reset asserted mid-access aborts the access immediately. No ack is issued and the strobes drop on the next edge.
- All outputs are registered.

States: IDLE, ADDR, WAIT, DATA.
- IDLE:
  - If any req is high, arbitrate and latch owner, we, addr and wdata. Go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - mem_addr is valid and grant is set.
  - mem_rd (read) or mem_wr plus mem_oe (write) assert.
  - Load wait counter = WAIT_STATES.
  - Go to WAIT, or to DATA if WAIT_STATES=0 and mem_ready=1.
  - If WAIT_STATES=0 and mem_ready=0, go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - Leave for DATA on the edge where counter ≤1 and mem_ready=1.
  - mem_ready low holds WAIT indefinitely.
  - For reads, mem_rdata is captured on the edge entering DATA.
- DATA:
  - Owner's ack=1 for exactly this cycle; owner's rdata holds the captured byte (reads).
  - Strobes remain asserted through DATA and drop on the return to IDLE.
  - The non-owner's ack and rdata stay 0.
  - Next state is IDLE.
- Latency: with WAIT_STATES=1 and mem_ready=1, req sampled in IDLE at cycle 0 gives ack in cycle 3. Each extra wait state or ready-low cycle adds 1.

Handshake rules
- A requester must drop req on the edge that samples ack=1.
- If req is still high in the following IDLE, that is a new access (back-to-back).
- Inputs other than req are sampled only in IDLE; later changes are ignored until the next access.

Arbitration (IDLE only)
- Only cpu_req: CPU wins.
- Only dma_req: DMA wins.
- Both: DMA wins unless burst counter = DMA_MAX_BURST, in which case CPU wins.
- Burst counter:
  - Increments on each DMA grant while cpu_req=1.
  - Clears on any CPU grant, or on a DMA grant with cpu_req=0.
  - Saturates at DMA_MAX_BURST.
- Simultaneous first requests after reset: DMA wins.

Outputs in IDLE
- mem_addr, mem_wdata, mem_oe, mem_rd, mem_wr and grant are all 0.
- cpu_rdata and dma_rdata return to 0 once the ack cycle ends.

Test Plan:
- Reset: assert reset for 2 cycles with cpu_req=1 -> all outputs 0, grant=00. Release -> cpu access begins, cpu_ack exactly 3 cycles after the first IDLE sample.
- CPU read: cpu_addr=0x1234, mem_rdata=0xA5, mem_ready=1 -> mem_addr=0x1234 for ADDR/WAIT/DATA, mem_rd=1 for 3 cycles, cpu_ack=1 one cycle with cpu_rdata=0xA5, mem_oe stays 0.
- CPU write with stall: cpu_we=1, addr=0x00FF, wdata=0x3C, mem_ready low 4 cycles -> mem_wr=1, mem_oe=1, mem_wdata=0x3C; ack delayed 4 cycles (cycle 7).
- Contention: cpu_req and dma_req both held continuously, DMA_MAX_BURST=4 -> grant sequence DMA,DMA,DMA,DMA,CPU,DMA,... and no requester starves.
- Reset mid-access: reset during WAIT -> no ack on either port; strobes 0 the next cycle; grant=00.
- WAIT_STATES=0: read with mem_ready=1 -> ack at cycle 2. Drop mem_ready once -> ack at cycle 3.
